// File: rtl/cdc_afifo_arb_pkg.sv
// Shared types and constants for the async-FIFO write-side arbiter family.
// Holds the arbiter FSM encoding, its register bundle and the counter widths.
package cdc_afifo_arb_pkg;

  localparam int CDC_ARB_BEAT_W = 8;
  localparam int CDC_ARB_STAT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    arb_state_e                state;
    logic [CDC_ARB_BEAT_W-1:0] beat_cnt;
  } arb_reg_t;

  localparam arb_reg_t ARB_REG_RST = '{state: IDLE, beat_cnt: '0};

  function automatic logic [CDC_ARB_STAT_W-1:0] sat_inc(input logic [CDC_ARB_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cdc_afifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write port of the write-side arbiter.
// The slave modport is the arbiter; the master modport is the requesters/FIFO side.
interface cdc_afifo_wr_arbiter_if #(
  parameter int nreq  = 4,
  parameter int dbits = 64
);
  localparam int idw = $clog2(nreq);

  logic [nreq-1:0]       i_req_valid;
  logic [nreq-1:0]       i_req_last;
  logic [nreq*dbits-1:0] i_req_data;
  logic [nreq-1:0]       o_req_ready;
  logic [idw-1:0]        o_gnt_id;
  logic                  o_busy;
  logic                  o_wr;
  logic [dbits+idw:0]    o_wdata;
  logic                  i_wfull;

  modport slave (
    input  i_req_valid, i_req_last, i_req_data, i_wfull,
    output o_req_ready, o_gnt_id, o_busy, o_wr, o_wdata
  );

  modport master (
    output i_req_valid, i_req_last, i_req_data, i_wfull,
    input  o_req_ready, o_gnt_id, o_busy, o_wr, o_wdata
  );

endinterface

// File: rtl/cdc_afifo_arb_rr_pick.sv
// Combinational rotate-priority picker: first set request strictly after ptr,
// wrapping modulo N (N need not be a power of two).
module cdc_afifo_arb_rr_pick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] pos;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int off = N; off >= 1; off--) begin
      pos = W'((int'(ptr) + off) % N);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/cdc_afifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among nreq requesters.
// Optional per-requester beat and stall counters: CDC_AFIFO_WR_ARBITER_STAT_EN.
module cdc_afifo_wr_arbiter
  import cdc_afifo_arb_pkg::*;
#(
  parameter int nreq      = 4,
  parameter int dbits     = 64,
  parameter int burst_max = 8
) (
  input  logic                           i_clk,
  input  logic                           i_nrst,
  cdc_afifo_wr_arbiter_if.slave          bus,
  output logic [nreq*CDC_ARB_STAT_W-1:0] o_stat_beats,
  output logic [CDC_ARB_STAT_W-1:0]      o_stat_stall
);

  localparam int idw = $clog2(nreq);
  localparam logic [idw-1:0]            RR_RST    = idw'(nreq - 1);
  localparam logic [CDC_ARB_BEAT_W-1:0] BEAT_LAST = CDC_ARB_BEAT_W'(burst_max - 1);

  arb_reg_t           reg_q, reg_d;
  logic [idw-1:0]     gnt_q, gnt_d;
  logic [idw-1:0]     rr_ptr_q, rr_ptr_d;

  logic               pick_found;
  logic [idw-1:0]     pick_idx;
  logic               sel_valid, sel_last;
  logic [dbits-1:0]   sel_data;
  logic               wr;
  logic [nreq-1:0]    ready;
  logic [dbits+idw:0] wdata;

  cdc_afifo_arb_rr_pick #(.N(nreq)) u_pick (
    .req   (bus.i_req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the granted requester's lane is ever steered towards the FIFO.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < nreq; k++) begin
      if (gnt_q == idw'(k)) begin
        sel_valid = bus.i_req_valid[k];
        sel_last  = bus.i_req_last[k];
        sel_data  = bus.i_req_data[k*dbits +: dbits];
      end
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    reg_d    = reg_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    wr       = 1'b0;
    ready    = '0;
    wdata    = '0;
    unique case (reg_q.state)
      IDLE: begin
        if (pick_found) begin
          gnt_d          = pick_idx;
          reg_d.beat_cnt = '0;
          reg_d.state    = BURST;
        end
      end
      BURST: begin
        for (int k = 0; k < nreq; k++) begin
          ready[k] = (gnt_q == idw'(k)) && !bus.i_wfull;
        end
        wr    = sel_valid && !bus.i_wfull;
        wdata = {sel_last, gnt_q, sel_data};
        if (wr) begin
          reg_d.beat_cnt = reg_q.beat_cnt + 1'b1;
          if (sel_last || (reg_q.beat_cnt == BEAT_LAST)) begin
            reg_d.state = IDLE;
            rr_ptr_d    = gnt_q;
          end
        end
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      reg_q    <= ARB_REG_RST;
      gnt_q    <= '0;
      rr_ptr_q <= RR_RST;
    end else begin
      reg_q    <= reg_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_wr        = wr;
  assign bus.o_wdata     = wdata;
  assign bus.o_busy      = (reg_q.state == BURST);
  assign bus.o_gnt_id    = gnt_q;

`ifdef CDC_AFIFO_WR_ARBITER_STAT_EN
  logic [CDC_ARB_STAT_W-1:0] beats_q [nreq];
  logic [CDC_ARB_STAT_W-1:0] beats_d [nreq];
  logic [CDC_ARB_STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    beats_d = beats_q;
    stall_d = stall_q;
    for (int k = 0; k < nreq; k++) begin
      if (wr && (gnt_q == idw'(k))) begin
        beats_d[k] = sat_inc(beats_q[k]);
      end
    end
    if ((reg_q.state == BURST) && sel_valid && bus.i_wfull) begin
      stall_d = sat_inc(stall_q);
    end
  end

  // NOTE: this array is a handful of discrete flops, not a RAM macro, so it
  // can take the async reset like any other register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int k = 0; k < nreq; k++) beats_q[k] <= '0;
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    o_stat_beats = '0;
    for (int k = 0; k < nreq; k++) begin
      o_stat_beats[k*CDC_ARB_STAT_W +: CDC_ARB_STAT_W] = beats_q[k];
    end
  end
  assign o_stat_stall = stall_q;
`else
  assign o_stat_beats = '0;
  assign o_stat_stall = '0;
`endif

endmodule

// File: tb/tb_cdc_afifo_wr_arbiter.sv
// Self-checking bench for cdc_afifo_wr_arbiter: directed scenarios plus a random
// phase, all checked cycle by cycle against a transaction-level arbiter model.
module tb_cdc_afifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DBITS = 16;
  localparam int BMAX  = 8;
  localparam int IDW   = 2;
  localparam int WW    = DBITS + IDW + 1;
  localparam int QD    = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdc_afifo_wr_arbiter_if #(.nreq(NREQ), .dbits(DBITS)) bus();
  logic [NREQ*16-1:0] stat_beats;
  logic [15:0]        stat_stall;

  cdc_afifo_wr_arbiter #(.nreq(NREQ), .dbits(DBITS), .burst_max(BMAX)) dut (
    .i_clk        (clk),
    .i_nrst       (rst_n),
    .bus          (bus),
    .o_stat_beats (stat_beats),
    .o_stat_stall (stat_stall)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-requester word streams: {last, data}
  logic [DBITS:0] qmem [NREQ][QD];
  int qh [NREQ];
  int qt [NREQ];
  int pushed_total;

  // Reference model: who holds the FIFO, who won last, beats in this grant.
  bit m_busy;
  int m_gnt, m_last, m_beats;
  int e_beats [NREQ];
  int e_stall;

  logic [WW-1:0] wlog [$];
  bit cur_full;

  task automatic push_word(input int k, input logic [DBITS-1:0] d, input bit l);
    qmem[k][qt[k]] = {l, d};
    qt[k]++;
    pushed_total++;
  endtask

  function automatic bit drained();
    for (int k = 0; k < NREQ; k++) if (qh[k] != qt[k]) return 1'b0;
    return !m_busy;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_gnt = 0; m_last = NREQ - 1; m_beats = 0; e_stall = 0;
    for (int k = 0; k < NREQ; k++) begin
      e_beats[k] = 0; qh[k] = 0; qt[k] = 0;
    end
    pushed_total = 0;
    wlog.delete();
  endtask

  task automatic drive(input int full_mode, input int vpct);
    for (int k = 0; k < NREQ; k++) begin
      if (qh[k] != qt[k]) begin
        bus.i_req_valid[k] = ($urandom_range(99) < vpct);
        bus.i_req_last[k]  = qmem[k][qh[k]][DBITS];
        bus.i_req_data[k*DBITS +: DBITS] = qmem[k][qh[k]][DBITS-1:0];
      end else begin
        bus.i_req_valid[k] = 1'b0;
        bus.i_req_last[k]  = 1'($urandom_range(1));
        bus.i_req_data[k*DBITS +: DBITS] = DBITS'($urandom);
      end
    end
    cur_full = (full_mode == 1) || ((full_mode == 2) && ($urandom_range(99) < 30));
    bus.i_wfull = cur_full;
  endtask

  task automatic check_cycle();
    logic [NREQ-1:0] er;
    logic [WW-1:0]   ew;
    bit v, l, ewr;
    int g, win;
    if (bus.o_wr) wlog.push_back(bus.o_wdata);
    if (!m_busy) begin
      check("idle_busy", bus.o_busy, 0);
      check("idle_ready", bus.o_req_ready, 0);
      check("idle_wr", bus.o_wr, 0);
      win = -1;
      for (int off = NREQ; off >= 1; off--) begin
        if (bus.i_req_valid[(m_last + off) % NREQ]) win = (m_last + off) % NREQ;
      end
      if (win >= 0) begin
        m_busy = 1'b1; m_gnt = win; m_beats = 0;
      end
    end else begin
      g   = m_gnt;
      v   = bus.i_req_valid[g];
      l   = qmem[g][qh[g]][DBITS];
      ewr = v && !cur_full;
      er  = '0;
      er[g] = !cur_full;
      check("burst_busy", bus.o_busy, 1);
      check("burst_gnt", bus.o_gnt_id, g);
      check("burst_ready", bus.o_req_ready, er);
      check("burst_wr", bus.o_wr, ewr);
      if (v && cur_full && e_stall < 65535) e_stall++;
      if (ewr) begin
        ew = {l, IDW'(g), qmem[g][qh[g]][DBITS-1:0]};
        check("burst_wdata", bus.o_wdata, ew);
        qh[g]++;
        m_beats++;
        if (e_beats[g] < 65535) e_beats[g]++;
        if (l || m_beats == BMAX) begin
          m_busy = 1'b0; m_last = g;
        end
      end
    end
  endtask

  task automatic step(input int full_mode, input int vpct);
    @(negedge clk);
    drive(full_mode, vpct);
    #1;
    check_cycle();
  endtask

  task automatic run_until_idle(input string tag, input int max_cyc, input int full_mode, input int vpct);
    int n = 0;
    while (!drained() && n < max_cyc) begin
      step(full_mode, vpct);
      n++;
    end
    check({tag, "_timeout"}, (n >= max_cyc), 0);
  endtask

  task automatic check_stats(input string tag);
    int eb, es;
    for (int k = 0; k < NREQ; k++) begin
`ifdef CDC_AFIFO_WR_ARBITER_STAT_EN
      eb = e_beats[k];
`else
      eb = 0;
`endif
      check($sformatf("%s_stat_beats%0d", tag, k), stat_beats[k*16 +: 16], eb);
    end
`ifdef CDC_AFIFO_WR_ARBITER_STAT_EN
    es = e_stall;
`else
    es = 0;
`endif
    check({tag, "_stat_stall"}, stat_stall, es);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_req_valid = '0; bus.i_req_last = '0; bus.i_req_data = '0; bus.i_wfull = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check({tag, "_rst_busy"}, bus.o_busy, 0);
    check({tag, "_rst_wr"}, bus.o_wr, 0);
    check({tag, "_rst_ready"}, bus.o_req_ready, 0);
    check({tag, "_rst_gnt"}, bus.o_gnt_id, 0);
    check({tag, "_rst_wdata"}, bus.o_wdata, 0);
    check_stats({tag, "_rst"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_ids [$];
    int stall_left, n;
    bit f;

    // 1: lone requester 2, three-beat burst
    do_reset("t1");
    for (int i = 0; i < 3; i++) push_word(2, DBITS'(16'hA000 + i), (i == 2));
    run_until_idle("t1", 20, 0, 100);
    check("t1_nwr", wlog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_word%0d", i), wlog[i], {(i == 2), 2'd2, DBITS'(16'hA000 + i)});
    end

    // 2: all requesting single-beat bursts -> 0,1,2,3,0,...
    do_reset("t2");
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NREQ; k++) push_word(k, DBITS'(16'hB000 + k*16 + j), 1'b1);
    run_until_idle("t2", 40, 0, 100);
    check("t2_nwr", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      check($sformatf("t2_order%0d", i), wlog[i][DBITS +: IDW], i % NREQ);
    end
    check_stats("t2");

    // 3: requester 1 streams 20 beats without last, requester 3 pending
    do_reset("t3");
    for (int i = 0; i < 20; i++) push_word(1, DBITS'(16'h1100 + i), 1'b0);
    for (int i = 0; i < 2; i++)  push_word(3, DBITS'(16'h3300 + i), 1'b1);
    for (int i = 0; i < 40; i++) step(0, 100);
    exp_ids.delete();
    for (int i = 0; i < 8; i++) exp_ids.push_back(1);
    exp_ids.push_back(3);
    for (int i = 0; i < 8; i++) exp_ids.push_back(1);
    exp_ids.push_back(3);
    for (int i = 0; i < 4; i++) exp_ids.push_back(1);
    check("t3_nwr", wlog.size(), exp_ids.size());
    for (int i = 0; i < exp_ids.size() && i < wlog.size(); i++) begin
      check($sformatf("t3_id%0d", i), wlog[i][DBITS +: IDW], exp_ids[i]);
    end
    check("t3_held_busy", bus.o_busy, 1);
    check("t3_held_gnt", bus.o_gnt_id, 1);
    check_stats("t3");

    // 4: FIFO full for five cycles after beat 2
    do_reset("t4");
    for (int i = 0; i < 5; i++) push_word(0, DBITS'(16'hC000 + i), (i == 4));
    n = 0;
    while (wlog.size() < 2 && n < 20) begin step(0, 100); n++; end
    check("t4_pre_timeout", (n >= 20), 0);
    for (int i = 0; i < 5; i++) step(1, 100);
    check("t4_full_nwr", wlog.size(), 2);
    run_until_idle("t4", 20, 0, 100);
    check("t4_nwr", wlog.size(), 5);
    if (wlog.size() > 2) check("t4_beat3", wlog[2], {1'b0, 2'd0, DBITS'(16'hC002)});
    check_stats("t4");

    // 5: asynchronous reset while beat 4 is on the bus
    do_reset("t5");
    for (int i = 0; i < 6; i++) push_word(2, DBITS'(16'h5500 + i), (i == 5));
    n = 0;
    while (wlog.size() < 3 && n < 20) begin step(0, 100); n++; end
    check("t5_pre_timeout", (n >= 20), 0);
    @(negedge clk);
    drive(0, 100);
    #1;
    check("t5_pre_wr", bus.o_wr, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_wr", bus.o_wr, 0);
    check("t5_async_ready", bus.o_req_ready, 0);
    check("t5_async_busy", bus.o_busy, 0);
    check("t5_async_gnt", bus.o_gnt_id, 0);
    model_reset();
    bus.i_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    push_word(3, DBITS'(16'h5A03), 1'b1);
    push_word(0, DBITS'(16'h5A00), 1'b1);
    run_until_idle("t5", 20, 0, 100);
    check("t5_nwr", wlog.size(), 2);
    if (wlog.size() > 0) check("t5_first_id", wlog[0][DBITS +: IDW], 0);

    // 6: statistics, 10 beats from requester 1 with 3 stall cycles
    do_reset("t6");
    for (int i = 0; i < 10; i++) push_word(1, DBITS'(16'h6600 + i), (i == 9));
    stall_left = 3;
    n = 0;
    while (!drained() && n < 60) begin
      @(negedge clk);
      f = m_busy && (wlog.size() >= 2) && (stall_left > 0);
      if (f) stall_left--;
      drive(f ? 1 : 0, 100);
      #1;
      check_cycle();
      n++;
    end
    check("t6_timeout", (n >= 60), 0);
    check("t6_nwr", wlog.size(), 10);
    @(negedge clk);
    bus.i_req_valid = '0;
    #1;
`ifdef CDC_AFIFO_WR_ARBITER_STAT_EN
    check("t6_beats1", stat_beats[16 +: 16], 10);
    check("t6_stall", stat_stall, 3);
`else
    check("t6_beats1", stat_beats[16 +: 16], 0);
    check("t6_stall", stat_stall, 0);
`endif
    check_stats("t6");

    // Random phase: random burst lengths, valid gaps and FIFO backpressure
    do_reset("rnd");
    for (int k = 0; k < NREQ; k++) begin
      n = $urandom_range(30, 5);
      for (int j = 0; j < n; j++) begin
        push_word(k, DBITS'($urandom), (j == n - 1) ? 1'b1 : ($urandom_range(3) == 0));
      end
    end
    run_until_idle("rnd", 3000, 2, 70);
    check("rnd_nwr", wlog.size(), pushed_total);
    @(negedge clk);
    bus.i_req_valid = '0;
    #1;
    check_stats("rnd");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
